wbu_regfile: RTL

- Writeback stage plus architectural register file. Sits downstream of the execute stage.
- Consumes the execute result triple (e_regW, e_regAddr, e_regData) through a valid/ready handshake, holds it for one stage, and commits it to the register file.
- Serves two combinational read ports to decode, with bypass from the pending writeback entry.

---
 rtl/wbu_regfile.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wbu_regfile.sv
// wbu_regfile: writeback stage holding one execute result, plus the
// architectural register file with two combinational read ports.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   e_valid / e_ready        execute-result handshake (transfer on both high)
//   e_regW, e_regAddr,       execute result: write enable, destination index,
//   e_regData                and value
//   wb_hold                  stall; blocks commit of the pending entry
//   rs1_addr / rs1_data      read port 1 (combinational, bypassed)
//   rs2_addr / rs2_data      read port 2 (combinational, bypassed)
//
// Optional feature (macro WBU_REGFILE_COMMIT_TRACE_EN):
//   commit_valid, commit_addr, commit_data, commit_count
//   A registered record of each commit, for the difftest harness.
//   With the macro undefined these ports and their logic do not exist.

module wbu_regfile #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    localparam int REG_NUM       = 1 << REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      e_valid,
    output logic                      e_ready,
    input  logic                      e_regW,
    input  logic [REG_ADDR_WIDTH-1:0] e_regAddr,
    input  logic [DATA_WIDTH-1:0]     e_regData,
    input  logic                      wb_hold,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs2_data
`ifdef WBU_REGFILE_COMMIT_TRACE_EN
    ,
    output logic                      commit_valid,
    output logic [REG_ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0]     commit_data,
    output logic [31:0]               commit_count
`endif
);
    // Purpose: one-entry writeback stage committing into a bypassed register file.
    // Latency: accept at edge N, commit at N+1; bypass visible from N+1, rf from N+2.
    // Backpressure: e_ready drops only while a pending entry is held by wb_hold.

    // ------------------------------------------------------------------
    // Pending writeback entry
    // ------------------------------------------------------------------
    logic                      wb_valid_q;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0]     wb_data_q;

    logic accept;
    logic commit;
    logic load_valid;

    // The stage is free when empty, or when its entry leaves on this edge.
    assign e_ready = !wb_valid_q || !wb_hold;
    assign accept  = e_valid && e_ready;
    assign commit  = wb_valid_q && !wb_hold;

    // Writes to x0 and non-writing results are consumed but never become
    // pending, so x0 can never be committed or bypassed.
    assign load_valid = e_regW && (e_regAddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else if (accept) begin
            // A new entry replaces the old one, which commits on this same
            // edge if it was valid (accept with a valid entry implies !wb_hold).
            wb_valid_q <= load_valid;
            wb_addr_q  <= e_regAddr;
            wb_data_q  <= e_regData;
        end else if (commit) begin
            wb_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Architectural register file
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rf [REG_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf[i] <= '0;
            end
        end else if (commit) begin
            // wb_addr_q is never 0 while wb_valid_q is set.
            rf[wb_addr_q] <= wb_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 forced to zero, then bypass from the pending entry
    // (regardless of wb_hold), else the register file.
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data = rf[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_valid_q && (wb_addr_q == rs1_addr)) begin
            rs1_data = wb_data_q;
        end
    end

    always_comb begin
        rs2_data = rf[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_valid_q && (wb_addr_q == rs2_addr)) begin
            rs2_data = wb_data_q;
        end
    end

`ifdef WBU_REGFILE_COMMIT_TRACE_EN
    // ------------------------------------------------------------------
    // Commit trace: registered copy of each commit, valid the cycle after
    // the commit edge, plus a free-running wrap-around commit counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
            commit_count <= '0;
        end else begin
            commit_valid <= commit;
            if (commit) begin
                commit_addr  <= wb_addr_q;
                commit_data  <= wb_data_q;
                commit_count <= commit_count + 32'd1;
            end
        end
    end
`endif

endmodule
